// File: rtl/chacha_stream_ctrl_if.sv
// Byte handshake bundle for chacha_stream_ctrl: host config, stream in/out, and ChaCha core side.
// The master side drives config, input bytes, downstream ready and core responses; the slave is the controller.
interface chacha_stream_ctrl_if;
  logic       cfg_wr;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       ctr_wrap;
  logic       blk_write;
  logic [7:0] blk_din;
  logic       blk_read;
  logic [7:0] blk_dout;
  logic       blk_ready;

  modport master (
    output cfg_wr, cfg_data, in_valid, in_data, out_ready, blk_dout, blk_ready,
    input  cfg_ready, in_ready, out_valid, out_data, ctr_wrap, blk_write, blk_din, blk_read
  );

  modport slave (
    input  cfg_wr, cfg_data, in_valid, in_data, out_ready, blk_dout, blk_ready,
    output cfg_ready, in_ready, out_valid, out_data, ctr_wrap, blk_write, blk_din, blk_read
  );
endinterface

// File: rtl/chacha_stream_ctrl.sv
// ChaCha stream sequencer: loads key/counter/nonce into the core per block and XORs keystream onto bytes.
// Stream path is combinational (zero latency); a stalled out_ready holds every piece of state.
module chacha_stream_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int CFG_BYTES   = 48
) (
  input logic           clk,
  input logic           rst_n,
  chacha_stream_ctrl_if.slave bus
);
  localparam int KW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int CW = $clog2(CFG_BYTES);
  localparam logic [CW-1:0] CB0 = CW'(32);
  localparam logic [CW-1:0] CB1 = CW'(33);
  localparam logic [CW-1:0] CB2 = CW'(34);
  localparam logic [CW-1:0] CB3 = CW'(35);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, STREAM, HALT} state_t;

  state_t        state_q;
  logic [CW-1:0] cfg_idx_q;
  logic [CW-1:0] ld_idx_q;
  logic [KW-1:0] ks_idx_q;
  logic [7:0]    cfg_mem_q [CFG_BYTES];
  logic [31:0]   ctr_q;
  logic          ctr_wrap_q;
  logic          blk_write_q;
  logic [7:0]    blk_din_q;

  logic          cfg_acc;
  logic          xfer;
  logic          cfg_last;
  logic          ld_last;
  logic          blk_last;
  logic [CW-1:0] ld_nxt;
  logic [7:0]    ld_byte;

  assign cfg_acc  = bus.cfg_wr && ((state_q == IDLE) || (state_q == HALT));
  assign xfer     = (state_q == STREAM) && bus.in_valid && bus.out_ready;
  assign cfg_last = (cfg_idx_q == CW'(CFG_BYTES - 1));
  assign ld_last  = (ld_idx_q == CW'(CFG_BYTES - 1));
  assign blk_last = (ks_idx_q == KW'(BLOCK_BYTES - 1));
  assign ld_nxt   = ld_idx_q + 1'b1;

  // Counter bytes come from the live counter so each reload carries the incremented value.
  always_comb begin
    ld_byte = cfg_mem_q[ld_nxt];
    case (ld_nxt)
      CB0:     ld_byte = ctr_q[7:0];
      CB1:     ld_byte = ctr_q[15:8];
      CB2:     ld_byte = ctr_q[23:16];
      CB3:     ld_byte = ctr_q[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cfg_acc) begin
      cfg_mem_q[cfg_idx_q] <= bus.cfg_data;
      case (cfg_idx_q)
        CB0:     ctr_q[7:0]   <= bus.cfg_data;
        CB1:     ctr_q[15:8]  <= bus.cfg_data;
        CB2:     ctr_q[23:16] <= bus.cfg_data;
        CB3:     ctr_q[31:24] <= bus.cfg_data;
        default: ;
      endcase
    end else if (xfer && blk_last) begin
      ctr_q <= ctr_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_idx_q   <= '0;
      ld_idx_q    <= '0;
      ks_idx_q    <= '0;
      ctr_wrap_q  <= 1'b0;
      blk_write_q <= 1'b0;
      blk_din_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (cfg_acc) begin
            ctr_wrap_q <= 1'b0;
            if (cfg_last) begin
              cfg_idx_q   <= '0;
              ld_idx_q    <= '0;
              blk_write_q <= 1'b1;
              blk_din_q   <= cfg_mem_q[0];
              state_q     <= LOAD;
            end else begin
              cfg_idx_q <= cfg_idx_q + 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_last) begin
            ld_idx_q    <= '0;
            blk_write_q <= 1'b0;
            state_q     <= SETTLE;
          end else begin
            ld_idx_q  <= ld_nxt;
            blk_din_q <= ld_byte;
          end
        end
        // The core still shows the previous block's ready here, so it is not looked at.
        SETTLE: state_q <= WAIT;
        WAIT: begin
          if (bus.blk_ready) state_q <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (blk_last) begin
              ks_idx_q <= '0;
              if (ctr_q == 32'hFFFF_FFFF) begin
                ctr_wrap_q <= 1'b1;
                state_q    <= HALT;
              end else begin
                ld_idx_q    <= '0;
                blk_write_q <= 1'b1;
                blk_din_q   <= cfg_mem_q[0];
                state_q     <= LOAD;
              end
            end else begin
              ks_idx_q <= ks_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (state_q == IDLE) || (state_q == HALT);
  assign bus.in_ready  = bus.out_ready && (state_q == STREAM);
  assign bus.out_valid = bus.in_valid && (state_q == STREAM);
  assign bus.out_data  = bus.in_data ^ bus.blk_dout;
  assign bus.blk_read  = xfer;
  assign bus.blk_write = blk_write_q;
  assign bus.blk_din   = blk_din_q;
  assign bus.ctr_wrap  = ctr_wrap_q;
endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl with a behavioural ChaCha20 core and a load/keystream scoreboard.
module tb_chacha_stream_ctrl;
  localparam int COMPUTE = 30;
  localparam int GAP     = COMPUTE + 4;

  logic clk;
  logic rst_n;
  chacha_stream_ctrl_if bus();

  chacha_stream_ctrl #(.BLOCK_BYTES(64), .CFG_BYTES(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Reference ChaCha20 block: bytes 0-31 key, 32-35 counter, 36-47 nonce, all little-endian.
  function automatic logic [511:0] chacha_ks(input logic [383:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] o;
    int b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = c[32*i +: 32];
    for (int i = 0; i < 4; i++) s[12+i] = c[256+32*i +: 32];
    x = s;
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 4; j++)
        {x[j], x[4+j], x[8+j], x[12+j]} = qr(x[j], x[4+j], x[8+j], x[12+j]);
      for (int j = 0; j < 4; j++) begin
        b = 4 + (j + 1) % 4; cc = 8 + (j + 2) % 4; d = 12 + (j + 3) % 4;
        {x[j], x[b], x[cc], x[d]} = qr(x[j], x[b], x[cc], x[d]);
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  // Behavioural core: ready stays stale until the cycle after the last load byte, then drops for the compute time.
  logic [383:0] cbuf;
  logic [511:0] cks;
  logic [5:0]   wcnt;
  logic [5:0]   rptr;
  logic         pend;
  logic         core_rdy;
  int           ccnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0; rptr <= '0; pend <= 1'b0; core_rdy <= 1'b1; ccnt <= 0; cks <= '0;
    end else begin
      if (bus.blk_write) begin
        cbuf[8*wcnt +: 8] <= bus.blk_din;
        if (wcnt == 6'd47) begin
          wcnt <= '0;
          pend <= 1'b1;
        end else begin
          wcnt <= wcnt + 6'd1;
        end
      end
      if (pend) begin
        pend     <= 1'b0;
        core_rdy <= 1'b0;
        ccnt     <= COMPUTE;
        cks      <= chacha_ks(cbuf);
        rptr     <= '0;
      end else if (!core_rdy) begin
        if (ccnt == 0) core_rdy <= 1'b1;
        else ccnt <= ccnt - 1;
      end
      if (bus.blk_read) rptr <= rptr + 6'd1;
    end
  end

  assign bus.blk_ready = core_rdy;
  assign bus.blk_dout  = cks[8*rptr +: 8];

  // Scoreboard state: expected load bytes queue plus the reference keystream of the current block.
  logic [7:0]   lq [$];
  logic [383:0] m_cfg;
  logic [31:0]  m_ctr;
  logic [511:0] ref_ks;
  int           m_pos = 0;
  int           cyc = 0;
  int           last_bw = 0;
  bit           armed = 1'b0;
  int           rd_cnt = 0;
  int           xfer_cnt = 0;
  logic [7:0]   first_out [4];

  task automatic push_load(input logic [383:0] c, input logic [31:0] ctr);
    for (int i = 0; i < 48; i++)
      lq.push_back((i >= 32 && i < 36) ? ctr[8*(i-32) +: 8] : c[8*i +: 8]);
  endtask

  always @(negedge clk) begin
    logic xf;
    logic [7:0] exp_b;
    if (!rst_n) begin
      armed = 1'b0;
    end else begin
      cyc++;
      if (bus.blk_write) begin
        if (lq.size() == 0) begin
          vecs++; errs++;
          $error("FAIL load_extra: observed blk_write with din %0h, expected no write", bus.blk_din);
        end else begin
          exp_b = lq.pop_front();
          chk("blk_din", 32'(bus.blk_din), 32'(exp_b));
        end
        last_bw = cyc;
        armed   = 1'b1;
      end
      if (armed && bus.in_valid && bus.out_ready) begin
        chk("stream_gap", 32'(bus.in_ready), 32'((cyc - last_bw) >= GAP));
        if (bus.in_ready) armed = 1'b0;
      end
      if (bus.blk_read) rd_cnt++;
      xf = bus.in_valid && bus.out_ready && bus.in_ready;
      chk("blk_read", 32'(bus.blk_read), 32'(xf));
      if (xf) begin
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("out_data", 32'(bus.out_data), 32'(bus.in_data ^ ref_ks[8*m_pos +: 8]));
        if (xfer_cnt < 4) first_out[xfer_cnt] = bus.out_data;
        xfer_cnt++;
        m_pos++;
        if (m_pos == 64) begin
          m_pos = 0;
          if (m_ctr == 32'hFFFF_FFFF) begin
            m_ctr = '0;
          end else begin
            m_ctr  = m_ctr + 32'd1;
            push_load(m_cfg, m_ctr);
            m_cfg[256 +: 32] = m_ctr;
            ref_ks = chacha_ks(m_cfg);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last byte is captured.
  task automatic cfg_send(input logic [383:0] c, input int from, input int to);
    if (from == 0) begin
      m_cfg  = c;
      m_ctr  = c[256 +: 32];
      m_pos  = 0;
      ref_ks = chacha_ks(c);
      push_load(c, m_ctr);
    end
    for (int i = from; i <= to; i++) begin
      bus.cfg_wr   = 1'b1;
      bus.cfg_data = c[8*i +: 8];
      @(posedge clk); #1;
    end
    bus.cfg_wr = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input int zeros, input bit noise);
    int  sent;
    int  budget;
    bit  xf;
    sent   = 0;
    budget = n * 4 + 400;
    bus.in_valid  = 1'b1;
    bus.in_data   = (zeros > 0) ? 8'h00 : 8'($urandom);
    bus.out_ready = 1'b1;
    while (sent < n && budget > 0) begin
      @(negedge clk);
      xf = bus.in_valid && bus.in_ready && bus.out_ready;
      @(posedge clk); #1;
      if (xf) begin
        sent++;
        bus.in_data = (sent < zeros) ? 8'h00 : 8'($urandom);
      end
      if (toggle) bus.out_ready = ~bus.out_ready;
      if (noise) begin
        bus.cfg_wr   = 1'b1;
        bus.cfg_data = 8'($urandom) | 8'h80;
      end
      budget--;
    end
    bus.in_valid  = 1'b0;
    bus.cfg_wr    = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_done", 32'(sent), 32'(n));
  endtask

  logic [383:0] c_rfc;
  logic [383:0] c_wrap;
  logic [383:0] c_new;
  int           base;
  int           bound;

  initial begin
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_data = 8'h00;
    bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    c_rfc = '0;
    for (int i = 0; i < 32; i++) c_rfc[8*i +: 8] = 8'(i);
    c_rfc[256 +: 32] = 32'd1;
    c_rfc[8*39 +: 8] = 8'h09;
    c_rfc[8*43 +: 8] = 8'h4a;

    #22;
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_blk_write", 32'(bus.blk_write), 32'd0);
    chk("rst_blk_din",   32'(bus.blk_din),   32'd0);
    chk("rst_blk_read",  32'(bus.blk_read),  32'd0);
    chk("rst_ctr_wrap",  32'(bus.ctr_wrap),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Partial config must wait in IDLE, then resume at the next index.
    cfg_send(c_rfc, 0, 19);
    repeat (8) begin
      @(negedge clk);
      chk("partial_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("partial_no_load",   32'(bus.blk_write), 32'd0);
    end
    @(posedge clk); #1;
    cfg_send(c_rfc, 20, 47);
    chk("load_starts", 32'(bus.blk_write), 32'd1);

    base = rd_cnt;
    stream(130, 1'b1, 64, 1'b0);
    chk("rfc_ks0", 32'(first_out[0]), 32'h10);
    chk("rfc_ks1", 32'(first_out[1]), 32'hf1);
    chk("rfc_ks2", 32'(first_out[2]), 32'he7);
    chk("rfc_ks3", 32'(first_out[3]), 32'he4);
    chk("blk_read_count", 32'(rd_cnt - base), 32'd130);

    // cfg_wr noise while streaming must leave the stored key untouched.
    stream(126, 1'b0, 0, 1'b1);
    chk("boundary_load", 32'(bus.blk_write), 32'd1);
    repeat (20) @(posedge clk);
    #2;
    chk("mid_load_bytes_left", 32'(lq.size()), 32'd28);
    rst_n = 1'b0;
    #1;
    chk("arst_blk_write", 32'(bus.blk_write), 32'd0);
    chk("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
    lq.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 48; i++) c_wrap[8*i +: 8] = 8'($urandom);
    c_wrap[256 +: 32] = 32'hFFFF_FFFF;
    cfg_send(c_wrap, 0, 47);
    stream(64, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_ctr_wrap",  32'(bus.ctr_wrap),  32'd1);
      chk("halt_in_ready",  32'(bus.in_ready),  32'd0);
      chk("halt_out_valid", 32'(bus.out_valid), 32'd0);
      chk("halt_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("halt_no_load",   32'(bus.blk_write), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    c_new = c_rfc;
    c_new[256 +: 32] = 32'd7;
    cfg_send(c_new, 0, 0);
    chk("wrap_cleared", 32'(bus.ctr_wrap), 32'd0);
    cfg_send(c_new, 1, 47);
    chk("resume_load", 32'(bus.blk_write), 32'd1);
    stream(70, 1'b1, 0, 1'b0);

    bound = 0;
    while (lq.size() != 0 && bound < 200) begin
      @(posedge clk);
      bound++;
    end
    #1;
    chk("load_queue_drained", 32'(lq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
